fir_sample_source: RTL and testbench

Programmable stimulus source that drives the FIR filter's sample input (`in_valid` / `in`). It produces bursts of impulse, step, ramp or pseudo-random samples with a configurable inter-sample gap. It sits directly upstream of `fir_filter` and replaces file-driven stimulus for on-chip self-test and bench bring-up.

---
 rtl/fir_sample_source.sv | 255 +++++++++++++++++++++++++
 tb/tb_fir_sample_source.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_source.sv
// ---------------------------------------------------------------------------
// fir_sample_source
//
// Programmable stimulus source for the FIR filter sample input. It emits
// bursts of impulse, step, ramp or LFSR-noise samples. A configurable number
// of idle cycles can be inserted between samples. Burst parameters are
// latched when a burst starts, so changes to the inputs mid-burst have no
// effect.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      begin a burst (accepted only in IDLE or DONE)
//   mode       0 impulse, 1 step, 2 ramp, 3 LFSR noise
//   amplitude  signed amplitude / ramp increment
//   burst_len  number of samples in the burst
//   gap        idle cycles inserted between samples
//   hold       freeze emission while high
//   out_valid  sample valid (drives filter in_valid)
//   out_data   signed sample (drives filter in)
//   sample_idx index of the sample on out_data
//   busy       burst in progress
//   done       one-cycle end-of-burst pulse
//
// Configuration macro:
//   FIR_SRC_SATURATE_EN  when defined, ramp samples saturate instead of
//                        wrapping on two's-complement overflow.
// ---------------------------------------------------------------------------
module fir_sample_source #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] amplitude,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [3:0]        gap,
  input  logic              hold,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [LEN_W-1:0]  sample_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0]  MODE_IMPULSE = 2'd0;
  localparam logic [1:0]  MODE_STEP    = 2'd1;
  localparam logic [1:0]  MODE_RAMP    = 2'd2;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;

  state_t             r_state;
  logic [1:0]         r_mode;
  logic [DATA_W-1:0]  r_amp;
  logic [LEN_W-1:0]   r_len;
  logic [3:0]         r_gap;
  logic [3:0]         r_gapCnt;
  logic [LEN_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_ramp;
  logic [15:0]        r_lfsr;
  logic               r_outValid;
  logic [DATA_W-1:0]  r_outData;
  logic [LEN_W-1:0]   r_sampleIdx;
  logic               r_busy;
  logic               r_done;

  state_t             w_nextState;
  logic               w_accept;
  logic               w_emit;
  logic               w_finish;
  logic [3:0]         w_nextGapCnt;
  logic [1:0]         w_mode;
  logic [DATA_W-1:0]  w_amp;
  logic [LEN_W-1:0]   w_len;
  logic [3:0]         w_gap;
  logic [LEN_W-1:0]   w_idx;
  logic [LEN_W-1:0]   w_idxInc;
  logic               w_lastEmit;
  logic [DATA_W-1:0]  w_ramp;
  logic [DATA_W-1:0]  w_rampNext;
  logic [15:0]        w_lfsr;
  logic [15:0]        w_lfsrNext;
  logic [DATA_W-1:0]  w_lfsrSample;
  logic [DATA_W-1:0]  w_sample;

  // A start accepted this cycle emits sample 0 on the same edge, so the
  // emission datapath sees the incoming parameters and a fresh index/ramp/
  // LFSR instead of the latched ones.
  assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && start;
  assign w_mode   = w_accept ? mode      : r_mode;
  assign w_amp    = w_accept ? amplitude : r_amp;
  assign w_len    = w_accept ? burst_len : r_len;
  assign w_gap    = w_accept ? gap       : r_gap;
  assign w_idx    = w_accept ? '0        : r_idx;
  assign w_ramp   = w_accept ? '0        : r_ramp;
  assign w_lfsr   = w_accept ? LFSR_SEED : r_lfsr;

  assign w_idxInc   = w_idx + LEN_W'(1);
  assign w_lastEmit = (w_idxInc == w_len);

  assign w_lfsrNext = {w_lfsr[14:0], w_lfsr[15] ^ w_lfsr[13] ^ w_lfsr[12] ^ w_lfsr[10]};

  // The LFSR is always 16 bits; narrower samples take its low bits and wider
  // samples see it zero-extended.
  generate
    if (DATA_W <= 16) begin : g_lfsrNarrow
      assign w_lfsrSample = w_lfsr[DATA_W-1:0];
    end else begin : g_lfsrWide
      assign w_lfsrSample = {{(DATA_W-16){1'b0}}, w_lfsr};
    end
  endgenerate

  // The ramp is kept as a running accumulator rather than k*amplitude.
  // Saturating accumulation gives the same result as saturating the product,
  // because once the sum clips, a constant increment keeps it clipped.
`ifdef FIR_SRC_SATURATE_EN
  logic [DATA_W:0] w_rampSum;

  assign w_rampSum = {w_ramp[DATA_W-1], w_ramp} + {w_amp[DATA_W-1], w_amp};

  always_comb begin
    w_rampNext = w_rampSum[DATA_W-1:0];
    if (w_rampSum[DATA_W] != w_rampSum[DATA_W-1]) begin
      w_rampNext = w_rampSum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign w_rampNext = w_ramp + w_amp;
`endif

  // Sample selection for the index that is about to be emitted.
  always_comb begin
    w_sample = '0;
    case (w_mode)
      MODE_IMPULSE: w_sample = (w_idx == '0) ? w_amp : '0;
      MODE_STEP:    w_sample = w_amp;
      MODE_RAMP:    w_sample = w_ramp;
      default:      w_sample = w_lfsrSample;
    endcase
  end

  // Next-state logic. Outputs are registered, so an "emission" here means the
  // sample is placed on out_data for the following cycle. EMIT with every
  // sample already sent is the last-sample cycle; leaving it raises done.
  always_comb begin
    w_nextState  = r_state;
    w_emit       = 1'b0;
    w_finish     = 1'b0;
    w_nextGapCnt = r_gapCnt;
    case (r_state)
      IDLE, DONE: begin
        w_nextState = IDLE;
        if (start) begin
          if (burst_len == '0) begin
            w_nextState = DONE;
            w_finish    = 1'b1;
          end else if (hold) begin
            w_nextState = EMIT;
          end else begin
            w_emit = 1'b1;
          end
        end
      end
      EMIT: begin
        if (!hold) begin
          if (r_idx == r_len) begin
            w_nextState = DONE;
            w_finish    = 1'b1;
          end else begin
            w_emit = 1'b1;
          end
        end
      end
      GAP: begin
        if (!hold) begin
          if (r_gapCnt == 4'd0) begin
            w_nextState = EMIT;
          end else begin
            w_nextGapCnt = r_gapCnt - 4'd1;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase

    // The gap counter is loaded with gap-1 so that the following emission
    // lands exactly gap+1 cycles after this one.
    if (w_emit) begin
      if (w_lastEmit || (w_gap == 4'd0)) begin
        w_nextState = EMIT;
      end else begin
        w_nextState  = GAP;
        w_nextGapCnt = w_gap - 4'd1;
      end
    end
  end

  // State, latched parameters, generator state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mode      <= '0;
      r_amp       <= '0;
      r_len       <= '0;
      r_gap       <= '0;
      r_gapCnt    <= '0;
      r_idx       <= '0;
      r_ramp      <= '0;
      r_lfsr      <= LFSR_SEED;
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_sampleIdx <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_gapCnt <= w_nextGapCnt;
      if (w_accept) begin
        r_mode <= mode;
        r_amp  <= amplitude;
        r_len  <= burst_len;
        r_gap  <= gap;
        r_idx  <= '0;
        r_ramp <= '0;
        r_lfsr <= LFSR_SEED;
      end
      if (w_emit) begin
        r_idx  <= w_idxInc;
        r_ramp <= w_rampNext;
        r_lfsr <= w_lfsrNext;
      end
      r_outValid  <= w_emit;
      r_outData   <= w_emit ? w_sample : '0;
      r_sampleIdx <= w_emit ? w_idx : '0;
      r_busy      <= (w_nextState == EMIT) || (w_nextState == GAP);
      r_done      <= w_finish;
    end
  end

  assign out_valid  = r_outValid;
  assign out_data   = r_outData;
  assign sample_idx = r_sampleIdx;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_fir_sample_source.sv
// ---------------------------------------------------------------------------
// tb_fir_sample_source
//
// Directed bench for fir_sample_source. A table of bursts with hand-computed
// sample values is played back and checked cycle by cycle. Hand-written
// sequences cover hold, start-while-busy, reset mid-burst and zero-length
// bursts. Honours FIR_SRC_SATURATE_EN for the ramp overflow vector.
// ---------------------------------------------------------------------------
module tb_fir_sample_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] amplitude;
  logic [15:0] burst_len;
  logic [3:0]  gap;
  logic        hold;
  logic        out_valid;
  logic [15:0] out_data;
  logic [15:0] sample_idx;
  logic        busy;
  logic        done;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    string            name;
    logic [1:0]       mode;
    logic [15:0]      amp;
    logic [15:0]      len;
    logic [3:0]       gap;
    logic [4:0][15:0] expSamples;
  } vec_t;

  vec_t vecs[$];

  fir_sample_source #(.DATA_W(16), .LEN_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .amplitude  (amplitude),
    .burst_len  (burst_len),
    .gap        (gap),
    .hold       (hold),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .sample_idx (sample_idx),
    .busy       (busy),
    .done       (done)
  );

  // 10-unit clock; inputs change after rising edges, outputs sampled on
  // falling edges.
  always #5 clk = ~clk;

  // Safety net in case the clock or the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input string n, input logic [1:0] m, input logic [15:0] a,
                        input logic [15:0] l, input logic [3:0] g,
                        input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                        input logic [15:0] e3, input logic [15:0] e4);
    vec_t v;
    v.name       = n;
    v.mode       = m;
    v.amp        = a;
    v.len        = l;
    v.gap        = g;
    v.expSamples = {e4, e3, e2, e1, e0};
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string tag, input logic eV, input logic [15:0] eD,
                             input logic [15:0] eI, input logic eB, input logic eDn);
    nTests++;
    if (out_valid !== eV) begin
      nFail++;
      $display("[TB] FAIL %s out_valid got %0b want %0b", tag, out_valid, eV);
    end
    nTests++;
    if (out_data !== eD) begin
      nFail++;
      $display("[TB] FAIL %s out_data got %0d want %0d", tag, $signed(out_data), $signed(eD));
    end
    nTests++;
    if (sample_idx !== eI) begin
      nFail++;
      $display("[TB] FAIL %s sample_idx got %0d want %0d", tag, sample_idx, eI);
    end
    nTests++;
    if (busy !== eB) begin
      nFail++;
      $display("[TB] FAIL %s busy got %0b want %0b", tag, busy, eB);
    end
    nTests++;
    if (done !== eDn) begin
      nFail++;
      $display("[TB] FAIL %s done got %0b want %0b", tag, done, eDn);
    end
  endtask

  // Plays one table burst and checks every cycle up to and including done.
  // Sample k is expected in cycle 1+k*(gap+1) after the start edge, done one
  // cycle after the last sample.
  task automatic applyStimulus(input vec_t v);
    int period;
    int doneC;
    period = int'(v.gap) + 1;
    doneC  = (int'(v.len) - 1) * period + 2;
    @(negedge clk);
    mode      = v.mode;
    amplitude = v.amp;
    burst_len = v.len;
    gap       = v.gap;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= doneC; c++) begin
      int   slot;
      int   k;
      logic eV;
      slot = c - 1;
      k    = slot / period;
      eV   = ((slot % period) == 0) && (k < int'(v.len));
      @(negedge clk);
      checkOutput($sformatf("%s c%0d", v.name, c), eV,
                  eV ? v.expSamples[k] : 16'h0000,
                  eV ? 16'(k) : 16'h0000,
                  c < doneC, c == doneC);
    end
  endtask

  initial begin
    logic [6:0] holdValid;
    int         holdIdx[7];

    reset     = 1'b1;
    start     = 1'b0;
    mode      = 2'd0;
    amplitude = 16'h0000;
    burst_len = 16'h0000;
    gap       = 4'd0;
    hold      = 1'b0;

    addVec("impulse",  2'd0, 16'h0064, 16'd4, 4'd0, 16'h0064, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    addVec("ramp_gap", 2'd2, 16'h0003, 16'd5, 4'd2, 16'h0000, 16'h0003, 16'h0006, 16'h0009, 16'h000C);
    addVec("lfsr1",    2'd3, 16'h1234, 16'd3, 4'd0, 16'hACE1, 16'h59C3, 16'hB387, 16'h0000, 16'h0000);
    addVec("lfsr2",    2'd3, 16'h0000, 16'd3, 4'd0, 16'hACE1, 16'h59C3, 16'hB387, 16'h0000, 16'h0000);
`ifdef FIR_SRC_SATURATE_EN
    addVec("ramp_ovf", 2'd2, 16'h4E20, 16'd3, 4'd0, 16'h0000, 16'h4E20, 16'h7FFF, 16'h0000, 16'h0000);
`else
    addVec("ramp_ovf", 2'd2, 16'h4E20, 16'd3, 4'd0, 16'h0000, 16'h4E20, 16'h9C40, 16'h0000, 16'h0000);
`endif
    addVec("step_gap", 2'd1, 16'hFFFB, 16'd2, 4'd1, 16'hFFFB, 16'hFFFB, 16'h0000, 16'h0000, 16'h0000);
    addVec("imp_gap3", 2'd0, 16'hFFF9, 16'd3, 4'd3, 16'hFFF9, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    addVec("ramp_neg", 2'd2, 16'hFFFE, 16'd4, 4'd0, 16'h0000, 16'hFFFE, 16'hFFFC, 16'hFFFA, 16'h0000);

    // Outputs must be clear while reset is asserted.
    #1 checkOutput("reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Step burst with hold high at the two edges after sample 1. A start and
    // new amplitude/length presented meanwhile must be ignored.
    holdValid = 7'b0110011;
    holdIdx   = '{0, 1, 0, 0, 2, 3, 0};
    @(negedge clk);
    mode      = 2'd1;
    amplitude = 16'hFFFB;
    burst_len = 16'd4;
    gap       = 4'd0;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checkOutput($sformatf("hold c%0d", c), holdValid[c-1],
                  holdValid[c-1] ? 16'hFFFB : 16'h0000,
                  16'(holdIdx[c-1]), c < 7, c == 7);
      if (c == 2) begin
        hold      = 1'b1;
        start     = 1'b1;
        amplitude = 16'h0063;
        burst_len = 16'd1;
      end
      if (c == 4) begin
        hold  = 1'b0;
        start = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("hold idle", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Reset during sample 2 of a length-8 step burst.
    @(negedge clk);
    mode      = 2'd1;
    amplitude = 16'h0007;
    burst_len = 16'd8;
    gap       = 4'd0;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("pre_rst c%0d", c), 1'b1, 16'h0007, 16'(c - 1), 1'b1, 1'b0);
    end
    #1 reset = 1'b1;
    #1 checkOutput("rst async", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst c%0d", c), 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    end

    // Zero-length burst: done alone in the cycle after the start edge.
    @(negedge clk);
    burst_len = 16'd0;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("len0 c1", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("len0 c2", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
